// File: rtl/sinc3_decimator_if.sv
`timescale 1ns/1ps
// Output-side bundle of sinc3_decimator: PCM word with valid/ready handshake,
// plus the sticky overrun flag and its clear.
interface sinc3_decimator_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output dout, dout_valid, overrun,
    input  dout_ready, ovr_clr
  );

  modport slave (
    input  dout, dout_valid, overrun,
    output dout_ready, ovr_clr
  );
endinterface

// File: rtl/sinc3_decimator.sv
`timescale 1ns/1ps
// sinc3_decimator: 3rd-order CIC decimator for the 1-bit modulator stream, R = 32..256.
// Define SINC3_SAT_EN to clamp the scaled word; otherwise it is truncated to OUT_W bits.
module sinc3_decimator #(
  parameter int OSR_LOG2_MAX = 8,
  parameter int OUT_W        = 16,
  parameter int SETTLE_N     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] osr_sel,
  input  logic       mod_op,
  output logic       busy,
  sinc3_decimator_if.master out_if
);
  // state  | meaning
  // IDLE   | filter held cleared, ratio latched from osr_sel
  // SETTLE | filter running, first SETTLE_N decimated outputs discarded
  // RUN    | every decimated output is written to the output register

  localparam int ACC_W = 3*OSR_LOG2_MAX + 1;
  localparam int CNT_W = OSR_LOG2_MAX;
  localparam int SET_W = $clog2(SETTLE_N + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic [3:0]       r_log2_q, r_log2_d;
  logic [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_last;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [ACC_W-1:0] samp_q, samp_d;
  logic             str_q, str_d;
  logic             run_str_q, run_str_d;
  logic [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [5:0]       sh;
  logic [OUT_W-1:0] y_q, y_d;
  logic             ywr_q, ywr_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             strobe;
  logic             accept;
  logic             ovr_set;
  logic [ACC_W-1:0] xm;

`ifdef SINC3_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  logic signed [ACC_W-1:0] y_full;
`endif

  assign xm       = x_q ? ACC_W'(1) : {ACC_W{1'b1}};
  assign cnt_last = CNT_W'((32'd1 << r_log2_q) - 32'd1);
  assign sh       = 6'(3 * r_log2_q) - 6'(OUT_W - 1);

  // Sequencing, integrators and decimation counter.
  always_comb begin
    state_d   = state_q;
    x_d       = mod_op;
    r_log2_d  = r_log2_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    samp_d    = samp_q;
    str_d     = 1'b0;
    run_str_d = 1'b0;
    strobe    = 1'b0;
    case (state_q)
      IDLE: begin
        r_log2_d = 4'd5 + {2'b00, osr_sel};
        i1_d     = '0;
        i2_d     = '0;
        i3_d     = '0;
        cnt_d    = '0;
        settle_d = '0;
        if (en) state_d = SETTLE;
      end
      SETTLE, RUN: begin
        i1_d   = i1_q + xm;
        i2_d   = i2_q + i1_d;
        i3_d   = i3_q + i2_d;
        strobe = (cnt_q == cnt_last);
        cnt_d  = strobe ? '0 : cnt_q + 1'b1;
        if (strobe) begin
          samp_d    = i3_d;
          str_d     = 1'b1;
          run_str_d = (state_q == RUN);
          if (state_q == SETTLE) begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SET_W'(SETTLE_N - 1)) state_d = RUN;
          end
        end
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Comb chain, scaling and the one-entry output register.
  always_comb begin
    c1      = samp_q - d1_q;
    c2      = c1 - d2_q;
    c3      = c2 - d3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    y_d     = y_q;
    ywr_d   = 1'b0;
`ifdef SINC3_SAT_EN
    y_full  = $signed(c3) >>> sh;
`endif
    if (str_q) begin
      d1_d  = samp_q;
      d2_d  = c1;
      d3_d  = c2;
      ywr_d = run_str_q;
`ifdef SINC3_SAT_EN
      if (y_full > Y_MAX)      y_d = {1'b0, {(OUT_W-1){1'b1}}};
      else if (y_full < Y_MIN) y_d = {1'b1, {(OUT_W-1){1'b0}}};
      else                     y_d = y_full[OUT_W-1:0];
`else
      y_d   = OUT_W'($signed(c3) >>> sh);
`endif
    end
    // y is taken from the old comb state above, so clearing here cannot corrupt it.
    if (state_q == IDLE) begin
      d1_d = '0;
      d2_d = '0;
      d3_d = '0;
    end

    accept  = valid_q & out_if.dout_ready;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (ywr_q) begin
      dout_d  = y_q;
      valid_d = 1'b1;
      ovr_set = valid_q & ~accept;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (ovr_set)             ovr_d = 1'b1;
    else if (out_if.ovr_clr) ovr_d = 1'b0;
    else                     ovr_d = ovr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= 1'b0;
      r_log2_q  <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      samp_q    <= '0;
      str_q     <= 1'b0;
      run_str_q <= 1'b0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      y_q       <= '0;
      ywr_q     <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      r_log2_q  <= r_log2_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      samp_q    <= samp_d;
      str_q     <= str_d;
      run_str_q <= run_str_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      y_q       <= y_d;
      ywr_q     <= ywr_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_if.dout       = dout_q;
  assign out_if.dout_valid = valid_q;
  assign out_if.overrun    = ovr_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_sinc3_decimator.sv
`timescale 1ns/1ps
// Bench for sinc3_decimator: the expected output stream comes from a direct sinc3 FIR
// (boxcar^3 convolution) over the recorded modulator samples, compared every cycle.
module tb_sinc3_decimator;
  localparam int OUT_W    = 16;
  localparam int SETTLE_N = 3;
`ifdef SINC3_SAT_EN
  localparam int FS_POS = 32767;
`else
  localparam int FS_POS = 32768;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] osr_sel = 2'd0;
  logic       mod_op = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  sinc3_decimator_if #(.OUT_W(OUT_W)) bus ();

  sinc3_decimator #(
    .OSR_LOG2_MAX(8),
    .OUT_W(OUT_W),
    .SETTLE_N(SETTLE_N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .osr_sel(osr_sel),
    .mod_op(mod_op),
    .busy(busy),
    .out_if(bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int               t;
    logic [OUT_W-1:0] v;
  } wr_t;

  int               t_edge = 0;
  bit               m_act = 0;
  int               m_R = 32;
  int               m_log2 = 5;
  int               m_j = 0;
  int               u_q[$];
  int               h[0:767];
  int               h_len = 0;
  wr_t              pend[$];
  logic [OUT_W-1:0] m_dout = '0;
  bit               m_valid = 0;
  bit               m_ovr = 0;

  function automatic void build_h(int r);
    int h2[0:511];
    for (int m = 0; m < 2*r-1; m++) h2[m] = (m+1 < 2*r-1-m) ? m+1 : 2*r-1-m;
    h_len = 3*r - 2;
    for (int m = 0; m < h_len; m++) begin
      h[m] = 0;
      for (int i = 0; i < r; i++)
        if (m-i >= 0 && m-i < 2*r-1) h[m] += h2[m-i];
    end
  endfunction

  function automatic logic [OUT_W-1:0] sinc_out(int k);
    int c, idx, ci, yi, sh;
    logic [24:0] cw;
    c = 0;
    for (int m = 0; m < h_len; m++) begin
      idx = k*m_R - m;
      if (idx >= 1) c += h[m] * u_q[idx-1];
    end
    cw = c[24:0];
    ci = int'($signed(cw));
    sh = 3*m_log2 - (OUT_W-1);
    yi = ci >>> sh;
`ifdef SINC3_SAT_EN
    if (yi > 2**(OUT_W-1) - 1) yi = 2**(OUT_W-1) - 1;
    if (yi < -(2**(OUT_W-1)))  yi = -(2**(OUT_W-1));
`endif
    return yi[OUT_W-1:0];
  endfunction

  function automatic bit wr_next();
    return (pend.size() > 0 && pend[0].t == t_edge + 1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_j = 0; pend.delete(); u_q.delete();
      m_dout = '0; m_valid = 0; m_ovr = 0;
    end else begin
      bit  wr, acc, set;
      wr_t w;
      t_edge++;
      wr  = (pend.size() > 0 && pend[0].t == t_edge);
      acc = m_valid && bus.dout_ready;
      set = 0;
      if (wr) begin
        set     = m_valid && !acc;
        m_dout  = pend[0].v;
        m_valid = 1;
        void'(pend.pop_front());
      end else if (acc) begin
        m_valid = 0;
      end
      if (set) m_ovr = 1;
      else if (bus.ovr_clr) m_ovr = 0;

      if (m_act) begin
        m_j++;
        if (m_j % m_R == 0 && m_j / m_R > SETTLE_N) begin
          w.t = t_edge + 2;
          w.v = sinc_out(m_j / m_R);
          pend.push_back(w);
        end
        if (!en) m_act = 0;
        else     u_q.push_back(mod_op ? 1 : -1);
      end else if (en) begin
        m_act  = 1;
        m_log2 = 5 + int'(osr_sel);
        m_R    = 1 << m_log2;
        m_j    = 0;
        u_q.delete();
        build_h(m_R);
        u_q.push_back(mod_op ? 1 : -1);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      n_checks++;
      if (bus.dout !== m_dout || bus.dout_valid !== m_valid ||
          bus.overrun !== m_ovr || busy !== m_act) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t dout=%h/%h valid=%b/%b ovr=%b/%b busy=%b/%b (actual/required)",
                 $time, bus.dout, m_dout, bus.dout_valid, m_valid, bus.overrun, m_ovr, busy, m_act);
      end
    end
  end

  // ---------------- background stimulus ----------------
  bit alt_on = 0, rnd_mod = 0, rnd_hs = 0;
  int dens = 50;

  initial forever begin
    @(negedge clk);
    if (alt_on)  mod_op = ~mod_op;
    if (rnd_mod) mod_op = ($urandom_range(0, 99) < dens);
    if (rnd_hs) begin
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      bus.ovr_clr    = ($urandom_range(0, 15) == 0);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(string name, int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.dout_valid && cyc < budget);
    if (!bus.dout_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s no dout_valid within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int cyc;
    bus.dout_ready = 1'b1;
    bus.ovr_clr    = 1'b0;
    tick(3);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_valid", int'(bus.dout_valid), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    // R=32, all ones: positive full scale
    osr_sel = 2'd0; mod_op = 1'b1; en = 1'b1;
    wait_valid("fs_first", 400, cyc);
    check("fs_first_latency", cyc, 4*32 + 3);
    check("fs_pos_value", int'(bus.dout), FS_POS);
    wait_valid("fs_period", 100, cyc);
    check("fs_period", cyc, 32);
    check("fs_pos_value2", int'(bus.dout), FS_POS);
    en = 1'b0;
    tick(3);
    check("idle_busy", int'(busy), 0);

    // R=256, all zeros: negative full scale
    osr_sel = 2'd3; mod_op = 1'b0; en = 1'b1;
    wait_valid("neg_first", 1200, cyc);
    check("neg_first_latency", cyc, 4*256 + 3);
    check("neg_value", int'(bus.dout), 32768);
    wait_valid("neg_period", 300, cyc);
    check("neg_period", cyc, 256);
    check("neg_value2", int'(bus.dout), 32768);
    en = 1'b0;
    tick(3);

    // R=64, alternating input averages to zero
    osr_sel = 2'd1; alt_on = 1; en = 1'b1;
    wait_valid("alt_first", 400, cyc);
    check("alt_first_latency", cyc, 4*64 + 3);
    check("alt_value", int'(bus.dout), 0);
    wait_valid("alt_second", 100, cyc);
    check("alt_value2", int'(bus.dout), 0);
    en = 1'b0; alt_on = 0;
    tick(3);

    // R=128, overrun handling
    osr_sel = 2'd2; dens = 70; rnd_mod = 1; en = 1'b1;
    wait_valid("ovr_first", 700, cyc);
    bus.dout_ready = 1'b0;
    tick(256);
    check("ovr_set", int'(bus.overrun), 1);
    check("ovr_valid_held", int'(bus.dout_valid), 1);
    bus.ovr_clr = 1'b1;
    tick(1);
    bus.ovr_clr = 1'b0;
    check("ovr_cleared", int'(bus.overrun), 0);
    cyc = 0;
    while (!wr_next() && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!wr_next()) begin
      n_checks++; n_fail++;
      $display("FAIL ovr_wait no pending write within 300 cycles");
    end
    bus.ovr_clr = 1'b1;
    tick(1);
    bus.ovr_clr = 1'b0;
    check("ovr_set_wins", int'(bus.overrun), 1);
    bus.dout_ready = 1'b1;
    tick(2);
    en = 1'b0;
    bus.ovr_clr = 1'b1;
    tick(1);
    bus.ovr_clr = 1'b0;
    tick(2);

    // ratio change while busy is ignored until the next IDLE pass
    osr_sel = 2'd0; en = 1'b1;
    tick(10);
    osr_sel = 2'd3;
    wait_valid("osr_hold_first", 400, cyc);
    wait_valid("osr_hold_period", 100, cyc);
    check("osr_hold_period", cyc, 32);
    en = 1'b0;
    tick(2);
    en = 1'b1;
    wait_valid("osr_new_first", 1200, cyc);
    check("osr_new_latency", cyc, 4*256 + 3);
    wait_valid("osr_new_period", 300, cyc);
    check("osr_new_period", cyc, 256);
    en = 1'b0;
    tick(2);

    // asynchronous reset mid-run
    osr_sel = 2'd0; en = 1'b1;
    wait_valid("rst_run_first", 400, cyc);
    bus.dout_ready = 1'b0;
    tick(5);
    check("rst_pre_valid", int'(bus.dout_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_dout", int'(bus.dout), 0);
    check("rst_async_valid", int'(bus.dout_valid), 0);
    check("rst_async_busy", int'(busy), 0);
    bus.dout_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    wait_valid("rst_resettle", 400, cyc);
    check("rst_resettle_latency", cyc, 4*32 + 3);
    en = 1'b0;
    tick(3);

    // random sessions
    rnd_hs = 1;
    for (int s = 0; s < 5; s++) begin
      int r_now;
      osr_sel = 2'($urandom_range(0, 1));
      dens    = $urandom_range(5, 95);
      r_now   = 32 << osr_sel;
      en      = 1'b1;
      for (int c = 0; c < 10*r_now + int'($urandom_range(0, 40)); c++) begin
        if (c == 50) osr_sel = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      en = 1'b0;
      tick($urandom_range(1, 3));
    end
    rnd_hs = 0; rnd_mod = 0;
    bus.dout_ready = 1'b1;
    bus.ovr_clr = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sinc3_decimator.md
Name: sinc3_decimator

Overview:
- Digital decimation stage directly downstream of the analog front end.
- Consumes the 1-bit modulator bitstream `mod_op`, which is produced synchronously to `clk`.
- Runs it through a 3rd-order CIC (sinc3) filter with a runtime-selectable oversampling ratio.
- Delivers signed PCM words through a one-entry valid/ready output register to the downstream logic (wishbone/logic-analyzer readout).

Parameters:
- OSR_LOG2_MAX, 8, log2 of the largest supported decimation ratio R; sets ACC_W = 3*OSR_LOG2_MAX+1 (25).
- OUT_W, 16, output word width, two's complement.
- SETTLE_N, 3, number of decimated outputs discarded after start.

Ports:
- clk  in  1  system clock, also the modulator clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; level sensitive.
- osr_sel  in  2  ratio select: 0=32, 1=64, 2=128, 3=256; sampled only in IDLE.
- mod_op  in  1  modulator bitstream from the analog front end.
- dout  out  OUT_W  decimated sample, signed.
- dout_valid  out  1  dout holds an unconsumed sample.
- dout_ready  in  1  consumer accepts dout when valid&ready at a rising edge.
- overrun  out  1  sticky: a sample was overwritten before acceptance.
- ovr_clr  in  1  synchronous clear of overrun.
- busy  out  1  high when state != IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low on `rst_n`.
- Reset values: all state, including integrators, combs and counters, reset to 0. Outputs reset to dout=0, dout_valid=0, overrun=0, busy=0.
- Input stage:
  - mod_op is registered once (x_q).
  - The mapped input is +1 when x_q=1 and -1 when x_q=0, sign-extended to ACC_W.
- FSM states: IDLE, SETTLE, RUN.
  - IDLE: latch r_log2 = 5+osr_sel. Clear integrators, combs, decimation counter and settle counter. If en=1, go to SETTLE next cycle.
  - SETTLE: filter runs. Decimated outputs are not written to dout. After SETTLE_N strobes, go to RUN.
  - RUN: every decimated output is written to the output register.
  - Any state: en=0 returns to IDLE next cycle. dout, dout_valid and overrun are retained, not cleared.
  - osr_sel changes while busy are ignored until the next IDLE pass.
- Integrators (SETTLE/RUN):
  - Three cascaded ACC_W-bit accumulators updated every clk.
  - Modulo-2^ACC_W wrap is intentional; no saturation inside the filter.
- Decimation counter:
  - Counts 0..R-1 with R = 2^r_log2, then wraps to 0.
  - Strobe fires on the cycle where cnt==R-1. At that edge the post-update value of integrator 3 is captured.
- Comb chain:
  - Three differentiators, differential delay 1, evaluated on the captured sample.
  - Comb delay registers update one cycle after the strobe.
  - Result c (ACC_W bits, wrap arithmetic) is valid in that cycle.
- Scaling: full scale of c is ±R^3. Output value is y = c >>> (3*r_log2 - (OUT_W-1)), arithmetic shift.
  - For R=32 the shift is 0 and y = c.
  - Positive full scale yields 2^(OUT_W-1), which is handled by the saturation rule below.
- Latency: dout/dout_valid update exactly 2 clk after the strobe edge.
- Output register:
  - On a write, dout ← y and dout_valid ← 1.
  - Acceptance (valid&ready) clears dout_valid.
  - If a write coincides with acceptance, the new sample is loaded, dout_valid stays 1 and overrun is not set.
  - If a write occurs while dout_valid=1 with no acceptance, the new sample overwrites and overrun ← 1.
  - overrun clears only via ovr_clr. If set and clear coincide, set wins.
- Reset mid-operation: immediate return to IDLE with all reset values; a partially accumulated sample is lost.

Optional Feature:
- Macro: SINC3_SAT_EN.
- Defined: y is clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]. Positive full scale (all-ones input) yields 0x7FFF for OUT_W=16.
- Undefined: y is truncated to OUT_W bits with no clamp. Positive full scale wraps to 0x8000. The clamp logic is absent.

Test Plan:
- osr_sel=0, en=1, mod_op held 1, dout_ready=1:
  - First dout_valid arrives after 4 strobes (3 discarded), strobes every 32 clk.
  - dout=0x7FFF with SINC3_SAT_EN, 0x8000 without.
- osr_sel=3, mod_op held 0 → steady dout=0x8000 (-32768); dout_valid pulses every 256 clk.
- osr_sel=1, mod_op alternating 1,0 → steady dout=0x0000 in RUN.
- osr_sel=2, dout_ready=0 for two decimation periods in RUN:
  - overrun=1 and dout holds the second sample.
  - ovr_clr pulse → overrun=0.
  - A simultaneous ovr_clr and new overrun leaves overrun=1.
- Change osr_sel 0→3 while busy=1 → output period stays 32 clk. After en=0 for 2 clk then en=1, the period becomes 256 clk.
- Assert rst_n=0 mid-RUN with dout_valid=1:
  - dout=0, dout_valid=0, busy=0 without waiting for a clock edge.
  - After release, the first output follows the full SETTLE discard.
